// File: rtl/hid_event_scheduler_if.sv
// Link between the HID event scheduler and the data_tx packet transmitter.
// The scheduler drives the issue pulses/data; data_tx reports session and busy state.
interface hid_event_scheduler_if;
  logic       online;
  logic       busy;
  logic       mouse_action;
  logic [7:0] mouse_data;
  logic       keyboard_action;
  logic [7:0] keyboard_data;

  modport master (
    input  online, busy,
    output mouse_action, mouse_data, keyboard_action, keyboard_data
  );

  modport slave (
    output online, busy,
    input  mouse_action, mouse_data, keyboard_action, keyboard_data
  );
endinterface

// File: rtl/hid_event_scheduler.sv
// Per-source FIFOs for mouse/keyboard HID bytes with a round-robin issue FSM
// that hands one event at a time to data_tx and tracks its busy handshake.
module hid_event_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_valid,
  input  logic [7:0]                   m_byte,
  input  logic                         k_valid,
  input  logic [7:0]                   k_byte,
  hid_event_scheduler_if.master        tx,
  output logic [$clog2(FIFO_DEPTH):0]  m_level,
  output logic [$clog2(FIFO_DEPTH):0]  k_level,
  output logic                         m_drop,
  output logic                         k_drop,
  output logic [7:0]                   drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo;
  logic          last_grant_k;

  logic [7:0]  m_mem [FIFO_DEPTH];
  logic [7:0]  k_mem [FIFO_DEPTH];
  logic [AW:0] m_wptr, m_rptr;
  logic [AW:0] k_wptr, k_rptr;

  logic m_full, k_full, m_ne, k_ne;
  logic m_push, k_push, m_ovf, k_ovf;
  logic grant_ok, grant_m, grant_k;
  logic [8:0] drop_sum;

  assign m_level = m_wptr - m_rptr;
  assign k_level = k_wptr - k_rptr;
  assign m_full  = (m_level == FULL_LEVEL);
  assign k_full  = (k_level == FULL_LEVEL);
  assign m_ne    = (m_level != '0);
  assign k_ne    = (k_level != '0);

  // Fullness uses the start-of-cycle level, so a same-cycle pop never rescues a byte.
  assign m_push = m_valid && tx.online && !m_full;
  assign k_push = k_valid && tx.online && !k_full;
  assign m_ovf  = m_valid && tx.online && m_full;
  assign k_ovf  = k_valid && tx.online && k_full;

  assign grant_ok = (state == IDLE) && tx.online && !tx.busy;
  assign grant_m  = grant_ok && m_ne && (!k_ne || last_grant_k);
  assign grant_k  = grant_ok && k_ne && !grant_m;

  assign drop_sum = {1'b0, drop_count} + {8'd0, m_ovf} + {8'd0, k_ovf};

  always_ff @(posedge clk) begin
    if (m_push) m_mem[m_wptr[AW-1:0]] <= m_byte;
    if (k_push) k_mem[k_wptr[AW-1:0]] <= k_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      tmo                <= '0;
      last_grant_k       <= 1'b1;
      m_wptr             <= '0;
      m_rptr             <= '0;
      k_wptr             <= '0;
      k_rptr             <= '0;
      m_drop             <= 1'b0;
      k_drop             <= 1'b0;
      drop_count         <= '0;
      tx.mouse_action    <= 1'b0;
      tx.mouse_data      <= '0;
      tx.keyboard_action <= 1'b0;
      tx.keyboard_data   <= '0;
    end else begin
      m_drop     <= m_ovf;
      k_drop     <= k_ovf;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (!tx.online) begin
        // Offline: flush both queues and abandon any handshake; data outputs hold.
        state              <= IDLE;
        tmo                <= '0;
        m_wptr             <= '0;
        m_rptr             <= '0;
        k_wptr             <= '0;
        k_rptr             <= '0;
        tx.mouse_action    <= 1'b0;
        tx.keyboard_action <= 1'b0;
      end else begin
        if (m_push)  m_wptr <= m_wptr + 1'b1;
        if (k_push)  k_wptr <= k_wptr + 1'b1;
        if (grant_m) m_rptr <= m_rptr + 1'b1;
        if (grant_k) k_rptr <= k_rptr + 1'b1;

        tx.mouse_action    <= 1'b0;
        tx.keyboard_action <= 1'b0;

        case (state)
          IDLE: begin
            if (grant_m) begin
              tx.mouse_data   <= m_mem[m_rptr[AW-1:0]];
              tx.mouse_action <= 1'b1;
              last_grant_k    <= 1'b0;
              state           <= ISSUE;
            end else if (grant_k) begin
              tx.keyboard_data   <= k_mem[k_rptr[AW-1:0]];
              tx.keyboard_action <= 1'b1;
              last_grant_k       <= 1'b1;
              state              <= ISSUE;
            end
          end
          ISSUE: begin
            tmo   <= TMO_LOAD;
            state <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (tx.busy)          state <= WAIT_DONE;
            else if (tmo == '0)   state <= IDLE;
            else                  tmo   <= tmo - 1'b1;
          end
          WAIT_DONE: begin
            if (!tx.busy) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/hid_event_scheduler.md
# hid_event_scheduler

Buffers and schedules HID events from the PS/2 mouse and keyboard decoders into the `data_tx` packet transmitter. Each source has a small FIFO. A round-robin scheduler issues one event at a time to `data_tx` as a one-cycle `mouse_action` / `keyboard_action` pulse, and waits for the transmitter's `busy` handshake to complete before issuing the next. Overflow is counted; all traffic is discarded while the link is offline.

## Interface
- `FIFO_DEPTH`, default 4: entries per source FIFO; power of two, ≥2.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `busy` to rise after an issue before abandoning the handshake.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `m_valid`  in  1: one-cycle strobe, mouse byte available.
- `m_byte`  in  8: mouse byte, valid with `m_valid`.
- `k_valid`  in  1: one-cycle strobe, keyboard scancode available.
- `k_byte`  in  8: keyboard scancode, valid with `k_valid`.
- `online`  in  1: from `data_tx`; high while the session is connected.
- `busy`  in  1: from `data_tx`; high while a packet is being built/sent.
- `mouse_action`  out  1: one-cycle issue pulse to `data_tx`.
- `mouse_data`  out  8: mouse byte; held from its pulse until the next mouse issue.
- `keyboard_action`  out  1: one-cycle issue pulse to `data_tx`.
- `keyboard_data`  out  8: scancode; held from its pulse until the next keyboard issue.
- `m_level`, `k_level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `m_drop`, `k_drop`  out  1: one-cycle pulse when a byte is discarded on a full FIFO.
- `drop_count`  out  8: total overflow drops, both sources; saturates at 255.

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; both FIFOs empty; `last_grant` = keyboard, so mouse wins the first tie.
- **FIFO write:** on `x_valid` with `online`=1:
  - Not full: push the byte.
  - Full (judged on the level at the start of the cycle, even if a pop occurs in the same cycle): discard, pulse `x_drop`, increment `drop_count` (saturating).
  - Simultaneous push and pop on a non-full FIFO: level unchanged.
- **Offline:** while `online`=0, incoming bytes are discarded silently (no drop pulse, no count), both FIFOs are flushed to empty, and the FSM forces IDLE.
  - `online` falling mid-handshake aborts the handshake immediately.
  - `*_data` outputs keep their last values.
- **FSM states:**
  - IDLE: if `online`=1 and `busy`=0 and at least one FIFO is non-empty, grant:
    - Only one source non-empty: grant that source.
    - Both non-empty: grant the source not equal to `last_grant`.
    - Pop its head into `x_data`, set the registered `x_action`, update `last_grant`, go to ISSUE.
  - ISSUE: `x_action` high for exactly this cycle; load timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - `busy`=1: go to WAIT_DONE.
    - Else decrement counter; at zero, return to IDLE (event abandoned, not re-queued).
  - WAIT_DONE: `busy`=0 returns to IDLE.
- At most one action pulse outstanding; `mouse_action` and `keyboard_action` are never high together.

## Timing
- Latency on an idle, online system: `m_valid` at cycle 0 → FIFO non-empty at cycle 1 (IDLE grants) → `mouse_action` at cycle 2, with `mouse_data` valid that same cycle.
- Minimum issue spacing: pulse, then ≥1 cycle in WAIT_BUSY, then WAIT_DONE for the `busy` duration, then 1 IDLE cycle. Back-to-back pulses are never possible.
- `busy`=1 while in IDLE blocks granting; FIFOs keep filling.
- Asynchronous reset deasserted mid-packet: outputs recover to the reset values above; no pulse on the first post-reset cycle.
- Level outputs update on the edge after a push or pop.

## Test plan
- **Single mouse event:** `online`=1, `busy`=0, `m_valid` with `m_byte`=0x3C → `mouse_action` exactly 2 cycles later with `mouse_data`=0x3C. Hold `busy` high 10 cycles → no further pulse; FSM returns to IDLE.
- **Round robin:** preload mouse {0x01,0x02} and keyboard {0xA1,0xA2} while `busy`=1, then release `busy` and emulate `busy` after each pulse → issue order mouse 0x01, kbd 0xA1, mouse 0x02, kbd 0xA2.
- **Overflow:** hold `busy`=1, send 6 mouse bytes (DEPTH 4) → `m_level`=4, two `m_drop` pulses, `drop_count`=2; after release, the first 4 bytes are issued in order.
- **Offline discard:** `online`=0, strobe 3 keyboard bytes → `k_level`=0, no drop pulses, no actions. Drop `online` while in WAIT_DONE with 2 queued → FSM IDLE, levels 0.
- **Timeout:** issue a keyboard event and keep `busy`=0 → FSM back in IDLE after 16 cycles in WAIT_BUSY; the next queued event is then issued.
- **Async reset:** assert `reset`=0 mid-handshake → all outputs 0 immediately; after release, the first tie between sources is granted to mouse.
